// File: rtl/sd_sector_dma_pkg.sv
// Shared definitions for the SD multi-sector read DMA: FSM encoding, sector geometry
// and the packed word layout pushed through the packing FIFO.
package sd_sector_dma_pkg;

    localparam int unsigned SD_HWORD_W     = 16;
    localparam int unsigned SD_WORD_W      = 32;
    localparam int unsigned SEC_ADDR_W     = 32;
    localparam int unsigned SEC_CNT_W      = 16;
    localparam int unsigned SD_SEC_HWORDS  = 256;
    localparam int unsigned SD_SEC_WORDS   = 128;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_INIT = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_XFER      = 3'd4,
        ST_NEXT      = 3'd5,
        ST_DRAIN     = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

    // First half-word of a pair lands in the upper half to keep byte order.
    typedef struct packed {
        logic [SD_HWORD_W-1:0] hi;
        logic [SD_HWORD_W-1:0] lo;
    } sd_word_t;

endpackage

// File: rtl/sd_sector_dma_fifo.sv
// Synchronous first-word-fall-through FIFO; a push on a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module sd_sector_dma_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             wr_en_c;
    logic             rd_en_c;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en_c = pop & ~empty;
    assign wr_en_c = push & (~full | rd_en_c);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_c) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_en_c) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sd_sector_dma.sv
// Multi-sector SD read sequencer: issues one start per sector, packs the 16-bit read
// stream into 32-bit words and writes them to memory at incrementing addresses.
module sd_sector_dma
    import sd_sector_dma_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                  clk_ref,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [SEC_ADDR_W-1:0] cfg_sec_addr,
    input  logic [SEC_CNT_W-1:0]  cfg_sec_cnt,
    input  logic [ADDR_W-1:0]     cfg_mem_base,
    input  logic                  sd_init_done,
    input  logic                  sd_rd_busy,
    input  logic                  sd_rd_val_en,
    input  logic [SD_HWORD_W-1:0] sd_rd_val_data,
    output logic                  sd_start,
    output logic [SEC_ADDR_W-1:0] sd_rd_sec_addr,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_W-1:0]     mem_wr_addr,
    output logic [SD_WORD_W-1:0]  mem_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_ovf
);

    state_e                  state_q, state_d;
    logic [SEC_ADDR_W-1:0]   sec_addr_q;
    logic [SEC_CNT_W-1:0]    remaining_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic                    sd_start_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_ovf_q;
    logic                    half_q;
    logic [SD_HWORD_W-1:0]   hi_q;
    logic                    push_q;
    sd_word_t                push_word_q;

    logic                    cfg_accept_c;
    logic                    sec_step_c;
    logic                    fifo_full_c;
    logic                    fifo_empty_c;
    logic                    fifo_pop_c;
    logic                    ovf_c;
    logic [SD_WORD_W-1:0]    fifo_dout_c;

    assign fifo_pop_c = ~fifo_empty_c & mem_wr_ready;
    assign ovf_c      = push_q & fifo_full_c & ~fifo_pop_c;

    // Sector sequencing
    always_comb begin
        state_d      = state_q;
        cfg_accept_c = 1'b0;
        sec_step_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    cfg_accept_c = 1'b1;
                    state_d      = (cfg_sec_cnt == '0) ? ST_DONE : ST_WAIT_INIT;
                end
            end
            ST_WAIT_INIT: if (sd_init_done) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (sd_rd_busy) state_d = ST_XFER;
            ST_XFER:      if (!sd_rd_busy) state_d = ST_NEXT;
            ST_NEXT: begin
                sec_step_c = 1'b1;
                state_d    = (remaining_q == SEC_CNT_W'(1)) ? ST_DRAIN : ST_ISSUE;
            end
            ST_DRAIN:     if (fifo_empty_c && !push_q) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sd_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
            sec_addr_q  <= '0;
            remaining_q <= '0;
            mem_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            sd_start_q <= (state_d == ST_ISSUE);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
            if (cfg_accept_c) begin
                sec_addr_q  <= cfg_sec_addr;
                remaining_q <= cfg_sec_cnt;
                mem_addr_q  <= cfg_mem_base & ~ADDR_W'(3);
                err_ovf_q   <= 1'b0;
            end else begin
                if (sec_step_c) begin
                    sec_addr_q  <= sec_addr_q + SEC_ADDR_W'(1);
                    remaining_q <= remaining_q - SEC_CNT_W'(1);
                end
                if (fifo_pop_c) mem_addr_q <= mem_addr_q + ADDR_W'(4);
                if (ovf_c) err_ovf_q <= 1'b1;
            end
        end
    end

    // Half-word packer; the stream cannot stall, so the word is pushed a cycle later
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            half_q      <= 1'b0;
            hi_q        <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (state_q == ST_XFER && sd_rd_val_en) begin
                if (!half_q) begin
                    hi_q   <= sd_rd_val_data;
                    half_q <= 1'b1;
                end else begin
                    push_q         <= 1'b1;
                    push_word_q.hi <= hi_q;
                    push_word_q.lo <= sd_rd_val_data;
                    half_q         <= 1'b0;
                end
            end
        end
    end

    sd_sector_dma_fifo #(
        .WIDTH (SD_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_ref),
        .rst   (rst),
        .push  (push_q),
        .pop   (fifo_pop_c),
        .din   (push_word_q),
        .dout  (fifo_dout_c),
        .full  (fifo_full_c),
        .empty (fifo_empty_c)
    );

    assign sd_start       = sd_start_q;
    assign sd_rd_sec_addr = sec_addr_q;
    assign mem_wr_valid   = ~fifo_empty_c;
    assign mem_wr_addr    = mem_addr_q;
    assign mem_wr_data    = fifo_dout_c;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_ovf        = err_ovf_q;

endmodule

// File: tb/tb_sd_sector_dma.sv
// Randomised bench for sd_sector_dma: a sector BFM feeds the DUT while a scoreboard of
// expected memory writes and sector addresses is checked every cycle.
module tb_sd_sector_dma;
    import sd_sector_dma_pkg::*;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 32;
    localparam int          NO_LIMIT = 1 << 30;

    logic              clk_ref = 1'b0;
    logic              rst;
    logic              cfg_start;
    logic [31:0]       cfg_sec_addr;
    logic [15:0]       cfg_sec_cnt;
    logic [ADDR_W-1:0] cfg_mem_base;
    logic              sd_init_done;
    logic              sd_rd_busy;
    logic              sd_rd_val_en;
    logic [15:0]       sd_rd_val_data;
    logic              sd_start;
    logic [31:0]       sd_rd_sec_addr;
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic              busy;
    logic              done;
    logic              err_ovf;

    sd_sector_dma #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_ref(clk_ref), .rst(rst), .cfg_start(cfg_start), .cfg_sec_addr(cfg_sec_addr),
        .cfg_sec_cnt(cfg_sec_cnt), .cfg_mem_base(cfg_mem_base), .sd_init_done(sd_init_done),
        .sd_rd_busy(sd_rd_busy), .sd_rd_val_en(sd_rd_val_en), .sd_rd_val_data(sd_rd_val_data),
        .sd_start(sd_start), .sd_rd_sec_addr(sd_rd_sec_addr), .mem_wr_valid(mem_wr_valid),
        .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done), .err_ovf(err_ovf)
    );

    always #5 clk_ref = ~clk_ref;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_sec_q[$];
    int          starts_seen, writes_seen, done_cnt, writes_expected;
    logic [31:0] first_data, last_addr, last_start;
    logic        stall_prev;
    logic [31:0] prev_data, prev_addr;
    int          ready_mode;
    int          word_idx, keep_limit;
    logic [31:0] xfer_base;
    logic [15:0] hw_ctr, hi_hw;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    // Memory-side ready pattern
    always @(posedge clk_ref) begin
        #1;
        case (ready_mode)
            0:       mem_wr_ready = 1'b1;
            1:       mem_wr_ready = ($urandom_range(0, 9) < 3);
            default: mem_wr_ready = 1'b0;
        endcase
    end

    // Per-cycle compare against the scoreboard
    always @(negedge clk_ref) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (sd_start) begin
                starts_seen++;
                last_start = sd_rd_sec_addr;
                if (exp_sec_q.size() == 0) chk("sd_start_unexpected", 64'(1), 64'(0));
                else chk("sd_start_addr", 64'(sd_rd_sec_addr), 64'(exp_sec_q.pop_front()));
            end
            if (stall_prev) begin
                chk("stall_valid", 64'(mem_wr_valid), 64'(1));
                chk("stall_data", 64'(mem_wr_data), 64'(prev_data));
                chk("stall_addr", 64'(mem_wr_addr), 64'(prev_addr));
            end
            if (mem_wr_valid && mem_wr_ready) begin
                if (writes_seen == 0) first_data = mem_wr_data;
                writes_seen++;
                last_addr = mem_wr_addr;
                if (exp_data_q.size() == 0) chk("write_unexpected", 64'(1), 64'(0));
                else begin
                    chk("write_addr", 64'(mem_wr_addr), 64'(exp_addr_q.pop_front()));
                    chk("write_data", 64'(mem_wr_data), 64'(exp_data_q.pop_front()));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last_write", 64'(writes_seen), 64'(writes_expected));
            end
            stall_prev = mem_wr_valid && !mem_wr_ready;
            prev_data  = mem_wr_data;
            prev_addr  = mem_wr_addr;
        end
    end

    task automatic start_cfg(input logic [31:0] a, input logic [15:0] cnt,
                             input logic [31:0] base, input int keep);
        int total;
        exp_sec_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < int'(cnt); i++) exp_sec_q.push_back(a + 32'(i));
        word_idx   = 0;
        keep_limit = keep;
        xfer_base  = base & ~32'h3;
        total      = int'(cnt) * SD_SEC_WORDS;
        writes_expected = (total < keep) ? total : keep;
        starts_seen = 0;
        writes_seen = 0;
        done_cnt    = 0;
        cfg_sec_addr = a;
        cfg_sec_cnt  = cnt;
        cfg_mem_base = base;
        cfg_start    = 1'b1;
        tick();
        cfg_start    = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk_ref);
            if (sd_start) ok = 1'b1;
        end
        if (!ok) chk("sd_start_timeout", 64'(0), 64'(1));
        tick();
    endtask

    // Controller BFM; the model pairs half-words into expected writes
    task automatic sd_sector(input int n_hw, input int max_gap, input bit seq, input bit end_sector);
        logic [15:0] hw;
        repeat ($urandom_range(0, 3)) tick();
        sd_rd_busy = 1'b1;
        tick();
        for (int i = 0; i < n_hw; i++) begin
            repeat ($urandom_range(0, max_gap)) tick();
            hw = seq ? hw_ctr : 16'($urandom);
            hw_ctr++;
            sd_rd_val_en   = 1'b1;
            sd_rd_val_data = hw;
            if (i % 2 == 0) hi_hw = hw;
            else begin
                if (word_idx < keep_limit) begin
                    exp_addr_q.push_back(xfer_base + 32'(4 * word_idx));
                    exp_data_q.push_back({hi_hw, hw});
                end
                word_idx++;
            end
            tick();
            sd_rd_val_en = 1'b0;
        end
        if (end_sector) begin
            tick();
            sd_rd_busy = 1'b0;
        end
    endtask

    task automatic run_sectors(input int n, input int max_gap, input bit seq);
        bit ok;
        for (int s = 0; s < n; s++) begin
            wait_start(ok);
            if (ok) sd_sector(SD_SEC_HWORDS, max_gap, seq, 1'b1);
        end
    endtask

    task automatic wait_done(input int n_starts);
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk_ref);
        if (done_cnt == 0) chk("done_timeout", 64'(0), 64'(1));
        repeat (5) tick();
        chk("done_count", 64'(done_cnt), 64'(1));
        chk("writes_total", 64'(writes_seen), 64'(writes_expected));
        chk("scoreboard_empty", 64'(exp_data_q.size()), 64'(0));
        chk("starts_total", 64'(starts_seen), 64'(n_starts));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sd_start"}, 64'(sd_start), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err_ovf"}, 64'(err_ovf), 64'(0));
        chk({tag, "_valid"}, 64'(mem_wr_valid), 64'(0));
        chk({tag, "_wr_addr"}, 64'(mem_wr_addr), 64'(0));
        chk({tag, "_wr_data"}, 64'(mem_wr_data), 64'(0));
        chk({tag, "_sec_addr"}, 64'(sd_rd_sec_addr), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1'b1; cfg_start = 1'b0; cfg_sec_addr = '0; cfg_sec_cnt = '0; cfg_mem_base = '0;
        sd_init_done = 1'b1; sd_rd_busy = 1'b0; sd_rd_val_en = 1'b0; sd_rd_val_data = '0;
        ready_mode = 0; hw_ctr = 16'd1; keep_limit = 0; word_idx = 0; xfer_base = '0;
        starts_seen = 0; writes_seen = 0; done_cnt = 0; writes_expected = 0;
        stall_prev = 1'b0; first_data = '0; last_addr = '0; last_start = '0;
        mem_wr_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk_ref);
        chk_reset_outputs("reset");

        // One sector, sequential data
        tick();
        hw_ctr = 16'd1;
        start_cfg(32'h10, 16'd1, 32'h1000, NO_LIMIT);
        run_sectors(1, 1, 1'b1);
        wait_done(1);
        chk("t1_first_data", 64'(first_data), 64'h0001_0002);
        chk("t1_last_addr", 64'(last_addr), 64'h11FC);
        chk("t1_start_addr", 64'(last_start), 64'h10);

        // Three sectors, sector and memory address wrap
        start_cfg(32'hFFFF_FFFF, 16'd3, 32'hFFFF_FE03, NO_LIMIT);
        run_sectors(3, 1, 1'b0);
        wait_done(3);
        chk("t2_last_start", 64'(last_start), 64'h1);
        chk("t2_last_addr", 64'(last_addr), 64'h3FC);
        chk("t2_err_ovf", 64'(err_ovf), 64'(0));

        // Random back-pressure, no overflow expected
        ready_mode = 1;
        start_cfg(32'h1234, 16'd1, 32'h8000_0000, NO_LIMIT);
        run_sectors(1, 3, 1'b0);
        wait_done(1);
        chk("t3_err_ovf", 64'(err_ovf), 64'(0));
        ready_mode = 0;

        // Memory stalled for a whole sector: FIFO keeps the first DEPTH words
        ready_mode = 2;
        start_cfg(32'h40, 16'd1, 32'h2000, DEPTH);
        run_sectors(1, 0, 1'b0);
        repeat (10) tick();
        chk("t4_err_ovf", 64'(err_ovf), 64'(1));
        chk("t4_busy_draining", 64'(busy), 64'(1));
        chk("t4_no_done_yet", 64'(done_cnt), 64'(0));
        chk("t4_no_writes_yet", 64'(writes_seen), 64'(0));
        ready_mode = 0;
        wait_done(1);
        chk("t4_err_ovf_sticky", 64'(err_ovf), 64'(1));

        // Zero-sector transfer
        exp_sec_q.delete(); writes_expected = 0; starts_seen = 0; writes_seen = 0; done_cnt = 0;
        cfg_sec_cnt = 16'd0; cfg_start = 1'b1;
        @(negedge clk_ref);
        chk("t5_done_before", 64'(done), 64'(0));
        tick();
        cfg_start = 1'b0;
        @(negedge clk_ref);
        chk("t5_done", 64'(done), 64'(1));
        chk("t5_busy", 64'(busy), 64'(1));
        chk("t5_err_ovf_cleared", 64'(err_ovf), 64'(0));
        tick();
        @(negedge clk_ref);
        chk("t5_done_pulse", 64'(done), 64'(0));
        chk("t5_idle", 64'(busy), 64'(0));
        repeat (5) tick();
        chk("t5_starts", 64'(starts_seen), 64'(0));
        chk("t5_writes", 64'(writes_seen), 64'(0));
        chk("t5_done_count", 64'(done_cnt), 64'(1));

        // Slow card init, then reset in the middle of a sector
        sd_init_done = 1'b0;
        start_cfg(32'h77, 16'd1, 32'h3000, NO_LIMIT);
        repeat (100) tick();
        chk("t6_no_start_before_init", 64'(starts_seen), 64'(0));
        chk("t6_busy_waiting", 64'(busy), 64'(1));
        sd_init_done = 1'b1;
        wait_start(ok);
        chk("t6_start_after_init", 64'(starts_seen), 64'(1));
        if (ok) sd_sector(100, 0, 1'b0, 1'b0);
        rst = 1'b1;
        exp_addr_q.delete(); exp_data_q.delete(); exp_sec_q.delete();
        keep_limit = 0;
        tick();
        chk_reset_outputs("t6_rst");
        rst = 1'b0;
        writes_seen = 0; done_cnt = 0; writes_expected = 0; starts_seen = 0;
        sd_sector(SD_SEC_HWORDS - 100, 0, 1'b0, 1'b1);
        repeat (30) tick();
        chk("t6_no_writes_after_rst", 64'(writes_seen), 64'(0));
        chk("t6_no_done_after_rst", 64'(done_cnt), 64'(0));
        chk("t6_no_start_after_rst", 64'(starts_seen), 64'(0));
        chk("t6_idle", 64'(busy), 64'(0));
        chk("t6_fifo_empty", 64'(mem_wr_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
